// File: rtl/uart_regs_pkg.sv
// Shared word map, register bit positions and helper types for the UART register file.
package uart_regs_pkg;

   typedef enum logic [2:0] {
      W_TX_DATA   = 3'd0,
      W_RX_DATA   = 3'd1,
      W_BAUD      = 3'd2,
      W_CONFIG    = 3'd3,
      W_STATUS    = 3'd4,
      W_INT_EN    = 3'd5,
      W_INT_STAT  = 3'd6,
      W_RX_THRESH = 3'd7
   } word_e;

   localparam int ST_TX_READY     = 0;
   localparam int ST_RX_NOT_EMPTY = 1;
   localparam int ST_RX_FULL      = 2;
   localparam int ST_PARITY_ERR   = 3;
   localparam int ST_OVERFLOW     = 4;
   localparam int ST_LEVEL_LSB    = 8;

   localparam int INT_TX_READY   = 0;
   localparam int INT_RX_THRESH  = 1;
   localparam int INT_PARITY_ERR = 2;
   localparam int INT_OVERFLOW   = 3;
   localparam int INT_RX_FULL    = 4;
   localparam int INT_W          = 5;

   typedef struct packed {
      logic parity_odd0_even1;
      logic parity_en;
      logic data_bits;
   } cfg_t;

   // The STATUS level field is 8 bits wide; a 256-deep FIFO that is full reads as 0xFF.
   function automatic logic [7:0] sat_level(input logic [8:0] lvl);
      return lvl[8] ? 8'hFF : lvl[7:0];
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: a full FIFO accepts a push only alongside a pop; an empty FIFO never pops.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop_ok;
   logic          w_push_ok;

   assign empty     = (r_count == '0);
   assign full      = (r_count == FULL_CNT);
   assign level     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_pop_ok  = pop & ~empty;
   assign w_push_ok = push & (~full | w_pop_ok);

   // NOTE: storage has no reset; only pointers and count define validity, so the array maps to plain RAM.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= din;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
      end
   end

endmodule

// File: rtl/uart_regs_fifo.sv
// UART register file: word decode, RX FIFO, sticky error flags, W1C interrupt status and irq.
module uart_regs_fifo
   import uart_regs_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int RX_FIFO_DEPTH = 8,
   parameter int BAUD_W        = 13
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic [ADDR_W-1:0]   ip_addr,
   input  logic [DATA_W-1:0]   ip_write_data,
   input  logic                valid_reg_write,
   input  logic                valid_reg_read,
   output logic [DATA_W-1:0]   ip_read_data,
   output logic                ip_read_data_valid,
   output logic                tx_data_reg_wr,
   output logic [7:0]          tx_data,
   input  logic                tx_ready,
   input  logic [7:0]          rx_byte,
   input  logic                rx_byte_valid,
   input  logic                rx_parity_err,
   output logic [BAUD_W-1:0]   baud_val,
   output logic                data_bits,
   output logic                parity_en,
   output logic                parity_odd0_even1,
   output logic                irq
);

   localparam int LVL_W = $clog2(RX_FIFO_DEPTH) + 1;

   word_e              w_sel;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic [7:0]         w_head;
   logic [LVL_W-1:0]   w_level;
   logic [8:0]         w_level_ext;
   logic               w_thresh_hit;
   logic               w_ovf_set;
   logic [INT_W-1:0]   w_w1c;
   logic [INT_W-1:0]   w_int_stat;
   logic [DATA_W-1:0]  w_rd_val;
   logic               w_unused;

   logic [BAUD_W-1:0]  r_baud;
   cfg_t               r_cfg;
   logic [INT_W-1:0]   r_int_en;
   logic [7:0]         r_thresh;
   logic               r_parity_err;
   logic               r_overflow;

   assign w_sel       = word_e'(ip_addr[4:2]);
   assign w_pop       = valid_reg_read && (w_sel == W_RX_DATA);
   assign w_level_ext = 9'(w_level);
   assign w_unused    = ^{ip_addr, ip_write_data};

   uart_rx_fifo #(
      .DEPTH (RX_FIFO_DEPTH),
      .W     (8)
   ) u_rx_fifo (
      .clk   (ACLK),
      .rst_n (ARESETn),
      .push  (rx_byte_valid),
      .pop   (w_pop),
      .din   (rx_byte),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (w_level)
   );

   // A full FIFO only overflows when no pop frees a slot in the same cycle.
   assign w_ovf_set    = rx_byte_valid & w_full & ~w_pop;
   assign w_thresh_hit = (r_thresh != 8'd0) && (w_level_ext >= {1'b0, r_thresh});
   assign w_w1c        = (valid_reg_write && (w_sel == W_INT_STAT)) ? ip_write_data[INT_W-1:0] : '0;

   always_comb begin
      w_int_stat                 = '0;
      w_int_stat[INT_TX_READY]   = tx_ready;
      w_int_stat[INT_RX_THRESH]  = w_thresh_hit;
      w_int_stat[INT_PARITY_ERR] = r_parity_err;
      w_int_stat[INT_OVERFLOW]   = r_overflow;
      w_int_stat[INT_RX_FULL]    = w_full;
   end

   // NOTE: every output of this mux is defaulted first so no path leaves it unassigned (no latch).
   always_comb begin
      w_rd_val = '0;
      case (w_sel)
         W_RX_DATA:   if (!w_empty) w_rd_val[7:0] = w_head;
         W_BAUD:      w_rd_val[BAUD_W-1:0] = r_baud;
         W_CONFIG:    w_rd_val[2:0] = r_cfg;
         W_STATUS: begin
            w_rd_val[ST_TX_READY]      = tx_ready;
            w_rd_val[ST_RX_NOT_EMPTY]  = ~w_empty;
            w_rd_val[ST_RX_FULL]       = w_full;
            w_rd_val[ST_PARITY_ERR]    = r_parity_err;
            w_rd_val[ST_OVERFLOW]      = r_overflow;
            w_rd_val[ST_LEVEL_LSB +: 8] = sat_level(w_level_ext);
         end
         W_INT_EN:    w_rd_val[INT_W-1:0] = r_int_en;
         W_INT_STAT:  w_rd_val[INT_W-1:0] = w_int_stat;
         W_RX_THRESH: w_rd_val[7:0] = r_thresh;
         default:     w_rd_val = '0;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_baud             <= '0;
         r_cfg              <= '0;
         r_int_en           <= '0;
         r_thresh           <= '0;
         r_parity_err       <= 1'b0;
         r_overflow         <= 1'b0;
         ip_read_data       <= '0;
         ip_read_data_valid <= 1'b0;
         irq                <= 1'b0;
      end else begin
         if (valid_reg_write) begin
            case (w_sel)
               W_BAUD:      r_baud   <= ip_write_data[BAUD_W-1:0];
               W_CONFIG:    r_cfg    <= cfg_t'(ip_write_data[2:0]);
               W_INT_EN:    r_int_en <= ip_write_data[INT_W-1:0];
               W_RX_THRESH: r_thresh <= ip_write_data[7:0];
               default:     ;
            endcase
         end
         // Set wins over a same-cycle write-1-to-clear.
         r_parity_err       <= rx_parity_err | (r_parity_err & ~w_w1c[INT_PARITY_ERR]);
         r_overflow         <= w_ovf_set | (r_overflow & ~w_w1c[INT_OVERFLOW]);
         ip_read_data_valid <= valid_reg_read;
         ip_read_data       <= valid_reg_read ? w_rd_val : '0;
         irq                <= |(w_int_stat & r_int_en);
      end
   end

   assign tx_data_reg_wr    = ARESETn && valid_reg_write && (w_sel == W_TX_DATA);
   assign tx_data           = ip_write_data[7:0];
   assign baud_val          = r_baud;
   assign data_bits         = r_cfg.data_bits;
   assign parity_en         = r_cfg.parity_en;
   assign parity_odd0_even1 = r_cfg.parity_odd0_even1;

endmodule

// File: tb/tb_uart_regs_fifo.sv
// Directed bench for uart_regs_fifo: a register vector table plus hand sequences for FIFO, W1C and irq timing.
module tb_uart_regs_fifo;
   import uart_regs_pkg::*;

   logic        ACLK;
   logic        ARESETn;
   logic [31:0] ip_addr;
   logic [31:0] ip_write_data;
   logic        valid_reg_write;
   logic        valid_reg_read;
   logic [31:0] ip_read_data;
   logic        ip_read_data_valid;
   logic        tx_data_reg_wr;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic [7:0]  rx_byte;
   logic        rx_byte_valid;
   logic        rx_parity_err;
   logic [12:0] baud_val;
   logic        data_bits;
   logic        parity_en;
   logic        parity_odd0_even1;
   logic        irq;

   int n_vec  = 0;
   int n_miss = 0;

   uart_regs_fifo #(
      .ADDR_W(32), .DATA_W(32), .RX_FIFO_DEPTH(8), .BAUD_W(13)
   ) dut (
      .ACLK               (ACLK),
      .ARESETn            (ARESETn),
      .ip_addr            (ip_addr),
      .ip_write_data      (ip_write_data),
      .valid_reg_write    (valid_reg_write),
      .valid_reg_read     (valid_reg_read),
      .ip_read_data       (ip_read_data),
      .ip_read_data_valid (ip_read_data_valid),
      .tx_data_reg_wr     (tx_data_reg_wr),
      .tx_data            (tx_data),
      .tx_ready           (tx_ready),
      .rx_byte            (rx_byte),
      .rx_byte_valid      (rx_byte_valid),
      .rx_parity_err      (rx_parity_err),
      .baud_val           (baud_val),
      .data_bits          (data_bits),
      .parity_en          (parity_en),
      .parity_odd0_even1  (parity_odd0_even1),
      .irq                (irq)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef enum logic [1:0] {K_WR, K_RD, K_RX, K_OUT} kind_e;
   typedef struct {
      kind_e       kind;
      word_e       word;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
      ip_addr = a; ip_write_data = d; valid_reg_write = 1'b1;
      tick();
      valid_reg_write = 1'b0;
   endtask

   task automatic wr(input word_e w, input logic [31:0] d);
      wr_addr({27'b0, w, 2'b00}, d);
   endtask

   task automatic rd_chk(input string name, input word_e w, input logic [31:0] exp);
      ip_addr = {27'b0, w, 2'b00}; valid_reg_read = 1'b1;
      tick();
      valid_reg_read = 1'b0;
      check({name, "_valid"}, 32'(ip_read_data_valid), 32'd1);
      check(name, ip_read_data, exp);
   endtask

   task automatic rx(input logic [7:0] b, input logic perr);
      rx_byte = b; rx_byte_valid = 1'b1; rx_parity_err = perr;
      tick();
      rx_byte_valid = 1'b0; rx_parity_err = 1'b0;
   endtask

   initial begin
      ARESETn = 1'b0; ip_addr = '0; ip_write_data = '0;
      valid_reg_write = 1'b0; valid_reg_read = 1'b0;
      tx_ready = 1'b1; rx_byte = '0; rx_byte_valid = 1'b0; rx_parity_err = 1'b0;

      vecs.push_back('{K_WR,  W_BAUD,      32'h0000_1ABC, 32'h0});
      vecs.push_back('{K_WR,  W_CONFIG,    32'h0000_0005, 32'h0});
      vecs.push_back('{K_RD,  W_BAUD,      32'h0,         32'h0000_1ABC});
      vecs.push_back('{K_RD,  W_CONFIG,    32'h0,         32'h0000_0005});
      vecs.push_back('{K_OUT, W_BAUD,      32'h0,         32'h0000_D5E5});
      vecs.push_back('{K_RD,  W_TX_DATA,   32'h0,         32'h0});
      vecs.push_back('{K_RX,  W_RX_DATA,   32'h11,        32'h0});
      vecs.push_back('{K_RX,  W_RX_DATA,   32'h22,        32'h0});
      vecs.push_back('{K_RX,  W_RX_DATA,   32'h33,        32'h0});
      vecs.push_back('{K_RD,  W_STATUS,    32'h0,         32'h0000_0303});
      vecs.push_back('{K_RD,  W_RX_DATA,   32'h0,         32'h11});
      vecs.push_back('{K_RD,  W_RX_DATA,   32'h0,         32'h22});
      vecs.push_back('{K_RD,  W_RX_DATA,   32'h0,         32'h33});
      vecs.push_back('{K_RD,  W_RX_DATA,   32'h0,         32'h0});
      vecs.push_back('{K_RD,  W_STATUS,    32'h0,         32'h0000_0001});
      vecs.push_back('{K_WR,  W_BAUD,      32'hFFFF_FFFF, 32'h0});
      vecs.push_back('{K_RD,  W_BAUD,      32'h0,         32'h0000_1FFF});
      vecs.push_back('{K_WR,  W_CONFIG,    32'h0000_00FF, 32'h0});
      vecs.push_back('{K_RD,  W_CONFIG,    32'h0,         32'h0000_0007});
      vecs.push_back('{K_WR,  W_STATUS,    32'h0000_FFFF, 32'h0});
      vecs.push_back('{K_RD,  W_STATUS,    32'h0,         32'h0000_0001});
      vecs.push_back('{K_WR,  W_INT_EN,    32'h0000_00FF, 32'h0});
      vecs.push_back('{K_RD,  W_INT_EN,    32'h0,         32'h0000_001F});
      vecs.push_back('{K_WR,  W_INT_EN,    32'h0,         32'h0});
      vecs.push_back('{K_RD,  W_INT_STAT,  32'h0,         32'h0000_0001});
      vecs.push_back('{K_WR,  W_RX_THRESH, 32'h0000_01FF, 32'h0});
      vecs.push_back('{K_RD,  W_RX_THRESH, 32'h0,         32'h0000_00FF});
      vecs.push_back('{K_WR,  W_RX_THRESH, 32'h0,         32'h0});

      // Reset state
      repeat (3) @(posedge ACLK);
      #1;
      check("rst_rdata", ip_read_data, 32'h0);
      check("rst_rvalid", 32'(ip_read_data_valid), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_txwr", 32'(tx_data_reg_wr), 32'h0);
      check("rst_cfg_out", {16'h0, baud_val, data_bits, parity_en, parity_odd0_even1}, 32'h0);
      ARESETn = 1'b1;
      tick();

      foreach (vecs[i]) begin
         case (vecs[i].kind)
            K_WR:  wr(vecs[i].word, vecs[i].data);
            K_RX:  rx(vecs[i].data[7:0], 1'b0);
            K_RD:  rd_chk($sformatf("vec%0d_rd", i), vecs[i].word, vecs[i].exp);
            K_OUT: check($sformatf("vec%0d_out", i),
                         {16'h0, baud_val, parity_odd0_even1, parity_en, data_bits}, vecs[i].exp);
            default: ;
         endcase
      end
      check("rdata_idle", ip_read_data, 32'h0);

      // TX write strobe is combinational and lasts one cycle
      ip_addr = 32'h0; ip_write_data = 32'h1A5; valid_reg_write = 1'b1;
      #1;
      check("tx_wr_pulse", 32'(tx_data_reg_wr), 32'h1);
      check("tx_data", 32'(tx_data), 32'hA5);
      tick();
      valid_reg_write = 1'b0;
      #1;
      check("tx_wr_end", 32'(tx_data_reg_wr), 32'h0);

      // Fill to full, overflow with parity error, then push+pop while full
      for (int i = 0; i < 8; i++) rx(8'h40 + 8'(i), 1'b0);
      rd_chk("full_status", W_STATUS, 32'h0000_0807);
      rx(8'h48, 1'b1);
      rd_chk("ovf_status", W_STATUS, 32'h0000_081F);
      wr(W_INT_STAT, 32'h0000_000C);
      rd_chk("w1c_status", W_STATUS, 32'h0000_0807);
      rx_byte = 8'h50; rx_byte_valid = 1'b1;
      ip_addr = {27'b0, W_RX_DATA, 2'b00}; valid_reg_read = 1'b1;
      tick();
      rx_byte_valid = 1'b0; valid_reg_read = 1'b0;
      check("pushpop_rdata", ip_read_data, 32'h40);
      rd_chk("pushpop_status", W_STATUS, 32'h0000_0807);
      for (int i = 1; i < 8; i++) rd_chk($sformatf("drain_%0d", i), W_RX_DATA, 32'h40 + 32'(i));
      rd_chk("drain_last", W_RX_DATA, 32'h50);

      // Overflow interrupt and W1C release
      wr(W_INT_EN, 32'h08);
      for (int i = 0; i < 8; i++) rx(8'h60 + 8'(i), 1'b0);
      rx(8'h68, 1'b0);
      check("irq_ovf_pre", 32'(irq), 32'h0);
      tick();
      check("irq_ovf_set", 32'(irq), 32'h1);
      wr(W_INT_STAT, 32'h08);
      check("irq_ovf_hold", 32'(irq), 32'h1);
      tick();
      check("irq_ovf_clr", 32'(irq), 32'h0);
      for (int i = 0; i < 8; i++) rd_chk($sformatf("drain2_%0d", i), W_RX_DATA, 32'h60 + 32'(i));
      rd_chk("drain2_empty", W_RX_DATA, 32'h0);

      // RX threshold interrupt
      wr(W_RX_THRESH, 32'h2);
      wr(W_INT_EN, 32'h02);
      rx(8'h71, 1'b0);
      tick();
      check("irq_thr_1", 32'(irq), 32'h0);
      rx(8'h72, 1'b0);
      tick();
      check("irq_thr_2", 32'(irq), 32'h1);
      rd_chk("thr_pop", W_RX_DATA, 32'h71);
      tick();
      check("irq_thr_drop", 32'(irq), 32'h0);

      // Parity set beats a same-cycle W1C
      rx_byte = 8'h73; rx_byte_valid = 1'b1; rx_parity_err = 1'b1;
      wr(W_INT_STAT, 32'h04);
      rx_byte_valid = 1'b0; rx_parity_err = 1'b0;
      rd_chk("perr_prio", W_STATUS, 32'h0000_020B);
      wr(W_INT_STAT, 32'h04);
      rd_chk("perr_w1c", W_INT_STAT, 32'h0000_0003);

      // Upper and lower address bits are ignored
      wr_addr(32'hABCD_000B, 32'h0123);
      rd_chk("alias_baud", W_BAUD, 32'h0000_0123);

      // Reset during a read and a push empties the FIFO and drops the read
      ARESETn = 1'b0;
      ip_addr = {27'b0, W_RX_DATA, 2'b00}; valid_reg_read = 1'b1;
      rx_byte = 8'h99; rx_byte_valid = 1'b1;
      tick();
      valid_reg_read = 1'b0; rx_byte_valid = 1'b0; ARESETn = 1'b1;
      check("rst_mid_rvalid", 32'(ip_read_data_valid), 32'h0);
      check("rst_mid_rdata", ip_read_data, 32'h0);
      rd_chk("rst_mid_status", W_STATUS, 32'h0000_0001);
      rd_chk("rst_mid_baud", W_BAUD, 32'h0);
      tx_ready = 1'b0;
      rd_chk("txrdy_low", W_STATUS, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/uart_regs_fifo.md
Name: uart_regs_fifo

Overview:
Next-generation UART register file that sits between the axi_slave register-side interface (ip_*) and the uart_tx / uart_rx datapaths. It replaces the single-byte RX data path with a parametrised receive FIFO. It adds sticky error flags, an interrupt enable register, a write-1-to-clear interrupt status register with a programmable RX threshold, and a parametrised baud divisor width. The interrupt output goes to the platform interrupt controller.

Parameters:
ADDR_W, 32, width of ip_addr
DATA_W, 32, width of ip_write_data / ip_read_data
RX_FIFO_DEPTH, 8, RX FIFO entries; power of two, 2..256
BAUD_W, 13, baud divisor width, 8..24

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset; synchronous, active-low
ip_addr  in  ADDR_W  register byte address; bits [4:2] select the word
ip_write_data  in  DATA_W  write data
valid_reg_write  in  1  single-cycle write strobe
valid_reg_read  in  1  single-cycle read strobe
ip_read_data  out  DATA_W  registered read data
ip_read_data_valid  out  1  read data valid
tx_data_reg_wr  out  1  TX push pulse to uart_tx
tx_data  out  8  TX byte, equal to ip_write_data[7:0]
tx_ready  in  1  TX can accept a byte
rx_byte  in  8  received byte
rx_byte_valid  in  1  one-cycle strobe from uart_rx
rx_parity_err  in  1  one-cycle strobe; parity error on the current rx_byte
baud_val  out  BAUD_W  baud divisor
data_bits  out  1  data-bit mode
parity_en  out  1  parity enable
parity_odd0_even1  out  1  parity select
irq  out  1  level interrupt, registered

Behaviour:
- Reset: all registers, FIFO pointers, count, sticky flags, ip_read_data, ip_read_data_valid and irq are 0. tx_data_reg_wr is 0.
- Word map, selected by ip_addr[4:2]:
  - 0 TX_DATA (W): write gives tx_data_reg_wr=1 in the same cycle, combinationally. Reads return 0.
  - 1 RX_DATA (R): read returns {0, head byte} and pops the FIFO. If the FIFO is empty, the read returns 0 and nothing pops.
  - 2 BAUD (RW): [BAUD_W-1:0] = baud_val. Other bits read 0.
  - 3 CONFIG (RW): [0] data_bits, [1] parity_en, [2] parity_odd0_even1. Other bits read 0.
  - 4 STATUS (R): [0] tx_ready, [1] rx_not_empty, [2] rx_full, [3] parity_err sticky, [4] overflow sticky, [15:8] rx_level. Upper bits 0.
  - 5 INT_EN (RW): [4:0] enables, bit-aligned with INT_STAT.
  - 6 INT_STAT (R, W1C):
    - [0] tx_ready (live level)
    - [1] rx_level >= RX_THRESH, with RX_THRESH != 0 (live level)
    - [2] parity_err sticky
    - [3] overflow sticky
    - [4] rx_full (live)
    - W1C applies to bits 2 and 3 only; these clear the STATUS copies too.
  - 7 RX_THRESH (RW): [7:0]. Values above RX_FIFO_DEPTH are never reached.
- Read latency: exactly 1 cycle.
  - ip_read_data_valid <= valid_reg_read.
  - ip_read_data <= selected value when valid_reg_read is 1, else 0.
  - The FIFO pop occurs in the strobe cycle; the returned byte is the pre-pop head.
- Writes to read-only words are ignored. Unused address bits are ignored, so address aliasing is accepted.
- RX FIFO push occurs when rx_byte_valid=1.
  - Full without a same-cycle pop: the byte is dropped, overflow is set and the FIFO is unchanged.
  - Full with a same-cycle pop: the push is accepted, no overflow, and the count stays at DEPTH.
  - Empty with a same-cycle push and pop: no pop (the empty rule applies), the push is accepted and the count becomes 1.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- rx_parity_err sets the parity_err sticky even if the accompanying byte is dropped.
- Set has priority over a same-cycle W1C clear.
- irq <= |(INT_STAT[4:0] & INT_EN[4:0]), registered. irq deasserts one cycle after the cause clears.
- A synchronous reset asserted mid-transfer empties the FIFO on the next edge. Any in-flight read data is discarded (valid=0).

Decomposition:
- Package uart_regs_pkg:
  - word offsets (3-bit)
  - STATUS and INT bit indices
  - INT_W=5
- Sub-module uart_rx_fifo (parameters DEPTH, W=8):
  - ports: push, pop, din, dout (head), full, empty, level
  - simultaneous-op rules as above
  - synchronous active-low reset
- The parent holds the register decode, the sticky flags, the read mux and irq.

Test Plan:
- Reset, then write BAUD=0x1ABC and CONFIG=0x5. Read both back one cycle later -> 0x1ABC and 0x5; baud_val=0x1ABC, data_bits=1, parity_en=0, parity_odd0_even1=1.
- Write TX_DATA=0x1A5 -> tx_data_reg_wr pulses 1 cycle with tx_data=0xA5. Reading TX_DATA -> 0.
- Push 0x11, 0x22, 0x33. STATUS -> level=3, rx_not_empty=1. Three RX_DATA reads -> 0x11, 0x22, 0x33. A fourth read -> 0, level stays 0.
- Push 9 bytes into a depth-8 FIFO:
  - overflow sticky=1, rx_full=1, and the ninth byte is dropped.
  - Push and pop in the same cycle while full -> no new overflow, level stays 8.
- Set INT_EN=0x08, then trigger an overflow -> irq=1 one cycle later. Write INT_STAT=0x08 -> overflow clears and irq=0 on the following cycle.
- Set RX_THRESH=2 and INT_EN=0x02. After 1 byte, irq=0. After the 2nd byte, irq=1. One RX_DATA read drops the level to 1 and irq=0.
